rom_ctrl_digest_cmp: RTL

Parametrised digest comparator for the ROM checker, successor to the single-word comparator. After `start_i` it walks the computed and expected digests in beats of `WordsPerCycle` words, compares every beat, and streams each computed beat to the key manager over a valid/ready handshake. It produces a multi-bit `good_o` verdict and can be re-armed with `clear_i`. It sits between the ROM KMAC digest CSRs and the key manager / power manager interfaces.

---
 rtl/rom_ctrl_pkg.sv | 23 ++
 rtl/rom_ctrl_digest_cmp_beat.sv | 48 ++++
 rtl/rom_ctrl_digest_cmp.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared types for the ROM controller digest comparator.
//   mubi4_t            : multi-bit boolean used for the check verdict
//   digest_cmp_state_e : sparse FSM encoding, pairwise Hamming distance >= 3
//   vbits()            : width helper that never returns 0
package rom_ctrl_pkg;

  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;

  // Idle^Check = 4 bits, Idle^Done = 3 bits, Check^Done = 3 bits.
  typedef enum logic [4:0] {
    DcIdle  = 5'b10110,
    DcCheck = 5'b01011,
    DcDone  = 5'b00101
  } digest_cmp_state_e;

  function automatic int unsigned vbits(int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rom_ctrl_digest_cmp_beat.sv
// Combinational beat slicer/comparator.
//   digest_i / exp_digest_i : full computed / expected digests, word 0 in LSBs
//   beat_idx_i              : beat to select
//   beat_data_o             : selected computed beat
//   beat_match_o            : whole beat equals the expected beat
//   word_mismatch_o         : one bit per word of the beat, set on mismatch
module rom_ctrl_digest_cmp_beat
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned NumWords      = 8,
  parameter int unsigned WordW         = 32,
  parameter int unsigned WordsPerCycle = 1,
  localparam int unsigned BeatW        = WordsPerCycle * WordW,
  localparam int unsigned NumBeats     = NumWords / WordsPerCycle,
  localparam int unsigned BeatIdxW     = vbits(NumBeats)
) (
  input  logic [NumWords*WordW-1:0] digest_i,
  input  logic [NumWords*WordW-1:0] exp_digest_i,
  input  logic [BeatIdxW-1:0]       beat_idx_i,
  output logic [BeatW-1:0]          beat_data_o,
  output logic                      beat_match_o,
  output logic [WordsPerCycle-1:0]  word_mismatch_o
);

  logic [BeatW-1:0] exp_beat;

  // Constant-offset mux; an out-of-range index yields zero data.
  always_comb begin
    beat_data_o = '0;
    exp_beat    = '0;
    for (int b = 0; b < int'(NumBeats); b++) begin
      if (beat_idx_i == BeatIdxW'(b)) begin
        beat_data_o = digest_i[b*BeatW +: BeatW];
        exp_beat    = exp_digest_i[b*BeatW +: BeatW];
      end
    end
  end

  always_comb begin
    word_mismatch_o = '0;
    for (int w = 0; w < int'(WordsPerCycle); w++) begin
      word_mismatch_o[w] = (beat_data_o[w*WordW +: WordW] != exp_beat[w*WordW +: WordW]);
    end
  end

  assign beat_match_o = ~|word_mismatch_o;

endmodule

// File: rtl/rom_ctrl_digest_cmp.sv
// Digest comparator for the ROM checker. After start_i it walks the computed
// and expected digests beat by beat, streams each computed beat to the key
// manager over valid/ready and produces a multi-bit verdict in Done.
// Optional feature macro: ROM_CTRL_DIGEST_CMP_MISMATCH_CNT_EN (per-word
// saturating mismatch counter on mismatch_cnt_o; tied to zero otherwise).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i, clear_i      : begin a check (Idle) / re-arm (Done)
//   digest_i, exp_digest_i: computed / expected digest, word 0 in LSBs
//   kmgr_valid_o/data_o/ready_i : beat stream to the key manager
//   done_o, good_o        : completion and mubi4 verdict
//   mismatch_cnt_o        : mismatching word count
//   alert_o               : fatal consistency alert (combinational)
module rom_ctrl_digest_cmp
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned NumWords      = 8,
  parameter int unsigned WordW         = 32,
  parameter int unsigned WordsPerCycle = 1,
  localparam int unsigned BeatW        = WordsPerCycle * WordW,
  localparam int unsigned NumBeats     = NumWords / WordsPerCycle,
  localparam int unsigned BeatIdxW     = vbits(NumBeats),
  localparam int unsigned CntW         = vbits(NumWords + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [NumWords*WordW-1:0] digest_i,
  input  logic [NumWords*WordW-1:0] exp_digest_i,
  output logic                      kmgr_valid_o,
  output logic [BeatW-1:0]          kmgr_data_o,
  input  logic                      kmgr_ready_i,
  output logic                      done_o,
  output mubi4_t                    good_o,
  output logic [CntW-1:0]           mismatch_cnt_o,
  output logic                      alert_o
);

  if (NumWords < 1 || (NumWords % WordsPerCycle) != 0) begin : gen_param_check
    $fatal(1, "rom_ctrl_digest_cmp: WordsPerCycle must divide NumWords >= 1");
  end

  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(NumBeats - 1);

  digest_cmp_state_e state_q, state_d;
  logic [BeatIdxW-1:0] beat_q, beat_d;
  logic [BeatIdxW-1:0] beat_inv_q;
  logic                match_q;
  mubi4_t              good_q;

  logic                     in_idle, in_check, in_done, state_err;
  logic                     hs, last_beat, cnt_err, rearm;
  logic                     beat_match;
  logic [WordsPerCycle-1:0] word_mismatch;
  logic [BeatW-1:0]         beat_data;

  rom_ctrl_digest_cmp_beat #(
    .NumWords      (NumWords),
    .WordW         (WordW),
    .WordsPerCycle (WordsPerCycle)
  ) u_beat (
    .digest_i        (digest_i),
    .exp_digest_i    (exp_digest_i),
    .beat_idx_i      (beat_q),
    .beat_data_o     (beat_data),
    .beat_match_o    (beat_match),
    .word_mismatch_o (word_mismatch)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DcIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; an invalid encoding is held so the alert stays up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DcIdle:  if (start_i)            state_d = DcCheck;
      DcCheck: if (hs && last_beat)    state_d = DcDone;
      DcDone:  if (clear_i)            state_d = DcIdle;
      default: state_d = state_q;
    endcase
  end

  // State decode outputs.
  always_comb begin
    in_idle   = 1'b0;
    in_check  = 1'b0;
    in_done   = 1'b0;
    state_err = 1'b0;
    case (state_q)
      DcIdle:  in_idle   = 1'b1;
      DcCheck: in_check  = 1'b1;
      DcDone:  in_done   = 1'b1;
      default: state_err = 1'b1;
    endcase
  end

  assign hs        = in_check & kmgr_ready_i;
  assign last_beat = (beat_q == LastBeat);
  assign rearm     = in_done & clear_i;

  // Redundant beat counter: a complemented shadow copy flags any upset.
  always_comb begin
    beat_d = beat_q;
    if (hs && !last_beat) beat_d = beat_q + BeatIdxW'(1);
    else if (rearm)       beat_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q     <= '0;
      beat_inv_q <= '1;
    end else begin
      beat_q     <= beat_d;
      beat_inv_q <= ~beat_d;
    end
  end

  assign cnt_err = (beat_q != ~beat_inv_q);

  // Running match flag and verdict; verdict includes the final beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match_q <= 1'b1;
      good_q  <= MuBi4False;
    end else if (hs) begin
      match_q <= match_q & beat_match;
      if (last_beat) good_q <= (match_q && beat_match) ? MuBi4True : MuBi4False;
    end else if (rearm) begin
      match_q <= 1'b1;
      good_q  <= MuBi4False;
    end
  end

`ifdef ROM_CTRL_DIGEST_CMP_MISMATCH_CNT_EN
  logic [CntW-1:0] mis_cnt_q;
  logic [CntW:0]   mis_sum;

  // Saturating accumulation of mismatching words in this beat.
  always_comb begin
    mis_sum = {1'b0, mis_cnt_q};
    for (int i = 0; i < int'(WordsPerCycle); i++) begin
      mis_sum = mis_sum + (CntW+1)'(word_mismatch[i]);
    end
    if (mis_sum[CntW]) mis_sum = {1'b0, {CntW{1'b1}}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      mis_cnt_q <= '0;
    else if (hs)    mis_cnt_q <= mis_sum[CntW-1:0];
    else if (rearm) mis_cnt_q <= '0;
  end

  assign mismatch_cnt_o = mis_cnt_q;
`else
  logic unused_word_mismatch;
  assign unused_word_mismatch = ^word_mismatch;
  assign mismatch_cnt_o       = '0;
`endif

  assign kmgr_valid_o = in_check;
  assign kmgr_data_o  = in_check ? beat_data : '0;
  assign done_o       = in_done;
  assign good_o       = good_q;

  assign alert_o = state_err
                 | (start_i & ~in_idle)
                 | (clear_i & in_check)
                 | (in_idle & (beat_q != '0))
                 | (in_done & (beat_q != LastBeat))
                 | cnt_err;

endmodule
